// File: rtl/muldiv_scheduler_if.sv
// Request/response bundle between the E stage / hazard unit and the HI/LO multiply-divide unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        rd_hilo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel, rd_hilo, wr_hi, wr_lo, wdata,
        input  busy, stall, done, hi, lo
    );
    modport slave (
        input  start, op, a, b, cancel, rd_hilo, wr_hi, wr_lo, wdata,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_scheduler.sv
// HI/LO multiply/divide sequencer: timed multiply, 32-step restoring divide, sign fix-up.
// Define MULDIV_MADD_EN to enable MADD/MADDU (ops 4/5) accumulating into {hi,lo}.
module muldiv_scheduler #(
    parameter int MUL_CYCLES = 4  // 1..15
) (
    input logic     clk,
    input logic     resetn,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
`ifdef MULDIV_MADD_EN
    logic        madd_q, madd_d;
`endif
    logic        op_valid, op_is_div, op_signed, accept, busy, done;
    logic [63:0] a_ext, b_ext, product, mul_result;
    logic [32:0] partial;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
`ifdef MULDIV_MADD_EN
        op_valid = (bus.op <= 3'd5);
`else
        op_valid = (bus.op <= 3'd3);
`endif
        op_is_div = (bus.op[2:1] == 2'b01);
        op_signed = ~bus.op[0];
        accept    = (state_q == IDLE) && bus.start && !bus.cancel && op_valid;
        busy      = (state_q != IDLE);

        a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
        b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
        product = a_ext * b_ext;
`ifdef MULDIV_MADD_EN
        mul_result = madd_q ? ({hi_q, lo_q} + product) : product;
`else
        mul_result = product;
`endif
        // One restoring step: shift next dividend bit into the partial remainder.
        partial = {rem_q, quo_q[31]};
        quo_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
        rem_fix = (sgn_q && a_q[31]) ? -rem_q : rem_q;
    end

    // NOTE: every next-state value gets its hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
`ifdef MULDIV_MADD_EN
        madd_d  = madd_q;
`endif
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sgn_d = op_signed;
                    a_d   = bus.a;
                    b_d   = bus.b;
`ifdef MULDIV_MADD_EN
                    madd_d = bus.op[2];
`endif
                    if (op_is_div) begin
                        state_d = DIV;
                        cnt_d   = 6'd31;
                        rem_d   = '0;
                        quo_d   = (op_signed && bus.a[31]) ? -bus.a : bus.a;
                        dvs_d   = (op_signed && bus.b[31]) ? -bus.b : bus.b;
                    end else begin
                        state_d = MUL;
                        cnt_d   = 6'(MUL_CYCLES - 1);
                    end
                end else begin
                    if (bus.wr_hi) hi_d = bus.wdata;
                    if (bus.wr_lo) lo_d = bus.wdata;
                end
            end
            MUL: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd0) begin
                    done         = 1'b1;
                    {hi_d, lo_d} = mul_result;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DIV: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    if (partial >= {1'b0, dvs_q}) begin
                        rem_d = 32'(partial - {1'b0, dvs_q});
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = partial[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == 6'd0) state_d = FIX;
                    else               cnt_d   = cnt_q - 6'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    done = 1'b1;
                    if (dvs_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand and divider working registers carry no reset; they are always
    // reloaded on the accepting edge before anything reads them.
    always_ff @(posedge clk) begin
        sgn_q <= sgn_d;
        a_q   <= a_d;
        b_q   <= b_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
`ifdef MULDIV_MADD_EN
        madd_q <= madd_d;
`endif
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    // An MFHI/MFLO in D must also wait behind an op being accepted in E this cycle.
    assign bus.stall = (busy && (bus.rd_hilo || bus.start || bus.wr_hi || bus.wr_lo))
                     || (accept && bus.rd_hilo);
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Self-checking bench for muldiv_scheduler: cycle-level result model plus directed literal checks.
module tb_muldiv_scheduler;
    localparam int MUL_CYCLES = 4;

    logic clk = 1'b0;
    logic resetn;
    muldiv_if bus ();

    muldiv_scheduler #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int done_total = 0;
    bit cmp_en = 1'b0;

    // Model: cycles of busy left, and the {hi,lo} value due when they run out.
    int          m_remain  = 0;
    logic [63:0] m_pending = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    function automatic bit model_accept();
        return (m_remain == 0) && bus.start && !bus.cancel && op_ok(bus.op);
    endfunction

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb;
        int          sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd1, 3'd5: p = {32'h0, a} * {32'h0, b};
            default:    p = sa * sb;
        endcase
        if (op[2]) p = p + acc;
        return p;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_remain <= 0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else if (m_remain > 0) begin
            if (bus.cancel) begin
                m_remain <= 0;
            end else begin
                if (m_remain == 1) {m_hi, m_lo} <= m_pending;
                m_remain <= m_remain - 1;
            end
        end else if (model_accept()) begin
            m_remain  <= (bus.op == 3'd2 || bus.op == 3'd3) ? 33 : MUL_CYCLES;
            m_pending <= model_result(bus.op, bus.a, bus.b, {m_hi, m_lo});
        end else begin
            if (bus.wr_hi) m_hi <= bus.wdata;
            if (bus.wr_lo) m_lo <= bus.wdata;
        end
    end

    task automatic clear_inputs();
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        bus.rd_hilo = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] d);
        @(negedge clk);
        bus.wr_hi = to_hi; bus.wr_lo = !to_hi; bus.wdata = d;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input int exp_done,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int b0, d0;
        b0 = busy_total;
        d0 = done_total;
        issue(op, a, b);
        wait_idle();
        check({name, "_busy_cycles"}, busy_total - b0, exp_busy);
        check({name, "_done_pulses"}, done_total - d0, exp_done);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, d0;
        clear_inputs();
        resetn = 1'b0;

        fork
            begin : compare
                bit e_busy, e_acc, e_done, e_stall;
                forever begin
                    @(negedge clk);
                    #3;
                    if (cmp_en) begin
                        e_busy  = (m_remain > 0);
                        e_acc   = model_accept();
                        e_done  = (m_remain == 1) && !bus.cancel;
                        e_stall = (e_busy && (bus.rd_hilo || bus.start || bus.wr_hi || bus.wr_lo))
                                || (e_acc && bus.rd_hilo);
                        check("busy", bus.busy, e_busy);
                        check("done", bus.done, e_done);
                        check("stall", bus.stall, e_stall);
                        check("hi", bus.hi, m_hi);
                        check("lo", bus.lo, m_lo);
                        if (bus.busy) busy_total++;
                        if (bus.done) done_total++;
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cmp_en = 1'b1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);

        run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 4, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 4, 1, 32'h4000_0000, 32'h0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 33, 1, 32'd2, 32'd14);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 33, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_5_0", 3'd2, 32'd5, 32'd0, 33, 1, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1, 32'h0, 32'h8000_0000);
        run_op("div_100_m7", 3'd2, 32'd100, 32'hFFFF_FFF9, 33, 1, 32'd2, 32'hFFFF_FFF2);
        run_op("divu_max_0", 3'd3, 32'hFFFF_FFFF, 32'd0, 33, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_max_16", 3'd3, 32'hFFFF_FFFF, 32'd16, 33, 1, 32'h0000_000F, 32'h0FFF_FFFF);
        run_op("div_m7_0", 3'd2, 32'hFFFF_FFF9, 32'd0, 33, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("reserved6", 3'd6, 32'd3, 32'd3, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("reserved7", 3'd7, 32'd3, 32'd3, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`ifndef MULDIV_MADD_EN
        run_op("madd_off", 3'd4, 32'd3, 32'd3, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`endif

        // MFLO in D and MTLO in E held against a running DIVU.
        b0 = busy_total;
        issue(3'd3, 32'd50, 32'd3);
        repeat (4) @(negedge clk);
        bus.rd_hilo = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
        #1 check("stall_lit_busy", bus.stall, 1'b1);
        wait_idle();
        check("stall_lit_idle", bus.stall, 1'b0);
        check("divu_50_3_busy_cycles", busy_total - b0, 33);
        check("divu_50_3_lo", bus.lo, 32'd16);
        @(negedge clk);
        bus.rd_hilo = 1'b0; bus.wr_lo = 1'b0;
        check("mtlo_after_idle_lo", bus.lo, 32'h1234);
        check("mtlo_after_idle_hi", bus.hi, 32'd2);

        mt(1'b1, 32'hAAAA_5555);
        check("mthi_hi", bus.hi, 32'hAAAA_5555);

        // Cancel in the 10th busy cycle of a DIV.
        d0 = done_total;
        issue(3'd2, 32'd9, 32'd2);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 1'b0);
        check("cancel_hi", bus.hi, 32'hAAAA_5555);
        check("cancel_lo", bus.lo, 32'h1234);
        repeat (3) @(negedge clk);
        check("cancel_no_done", done_total - d0, 0);

        // cancel in IDLE blocks the accept.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("idle_cancel_busy", bus.busy, 1'b0);

        // start wins over a same-cycle MTHI.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd4;
        bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        wait_idle();
        check("start_wins_hi", bus.hi, 32'h0);
        check("start_wins_lo", bus.lo, 32'd12);

        // MFHI in D alongside an accepted start stalls.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd6; bus.b = 32'd7; bus.rd_hilo = 1'b1;
        #1 check("stall_on_accept", bus.stall, 1'b1);
        @(negedge clk);
        bus.start = 1'b0; bus.rd_hilo = 1'b0;
        wait_idle();
        check("mul_6x7_lo", bus.lo, 32'd42);

        // Synchronous reset in the middle of a MULT.
        issue(3'd0, 32'd5, 32'd6);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_hi", bus.hi, 32'h0);
        check("rst_mid_lo", bus.lo, 32'h0);
        repeat (5) @(negedge clk);
        check("rst_mid_lo_stays", bus.lo, 32'h0);

`ifdef MULDIV_MADD_EN
        mt(1'b1, 32'hFFFF_FFFF);
        mt(1'b0, 32'hFFFF_FFFF);
        run_op("maddu_wrap", 3'd5, 32'd1, 32'd1, 4, 1, 32'h0, 32'h0);
        mt(1'b0, 32'd5);
        run_op("madd_neg", 3'd4, 32'hFFFF_FFFF, 32'd2, 4, 1, 32'h0, 32'd3);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
